// File: rtl/sample_arbiter_ctrl_if.sv
// Request/latch handshake bundle between requesters and the sampling-latch sequencer.
interface sample_arbiter_ctrl_if #(
  parameter int unsigned NREQ = 4
) ();
  localparam int unsigned GW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic            go_ml;
  logic            sample;
  logic [NREQ-1:0] ack;
  logic [GW-1:0]   grant_id;
  logic            busy;

  modport master (
    output req,
    output go_ml,
    input  sample,
    input  ack,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req,
    input  go_ml,
    output sample,
    output ack,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/sample_arbiter_ctrl.sv
// Round-robin sequencer sharing one sampling latch among NREQ four-phase requesters:
// grant -> one-cycle sample pulse -> HOLD_CYC settle cycles -> ack until req drops.
module sample_arbiter_ctrl #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sample_arbiter_ctrl_if.slave arb_if
);
  localparam int unsigned GW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StSample, StHold, StAck} state_e;

  state_e          state_q, state_d;
  logic            sample_q, sample_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [GW-1:0]   pick;
  logic [GW-1:0]   idx;
  logic            found;
  logic [NREQ-1:0] grant_oh;

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    pick  = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = GW'((32'(ptr_q) + k) % NREQ);
      if (!found && arb_if.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    ack_d    = ack_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_if.go_ml && found) begin
          state_d  = StSample;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          grant_d  = pick;
        end
      end
      StSample: begin
        sample_d = 1'b0;
        if (HOLD_CYC == 0) begin
          state_d = StAck;
          ack_d   = grant_oh;
        end else begin
          state_d = StHold;
          cnt_d   = 4'(HOLD_CYC);
        end
      end
      // Grant is committed here: req and go_ml are deliberately not looked at.
      StHold: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StAck;
          ack_d   = grant_oh;
          cnt_d   = 4'd0;
        end
      end
      StAck: begin
        if (!arb_if.req[grant_q]) begin
          state_d = StIdle;
          ack_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign arb_if.sample   = sample_q;
  assign arb_if.busy     = busy_q;
  assign arb_if.ack      = ack_q;
  assign arb_if.grant_id = grant_q;
endmodule
